// File: rtl/game_state_manager.sv
`default_nettype none
// ============================================================================
// game_state_manager : frame-evaluated game FSM (score, lives, level, blink).
// Optional macro BONUS_LIFE_EN: extra life at each 100-point boundary. Rev 1.0
// ============================================================================
module game_state_manager #(
    parameter int PRIZE_POINTS       = 10,
    parameter int INVULN_FRAMES      = 60,
    parameter int LEVEL_PAUSE_FRAMES = 90
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       start_key,
    input  logic       tile_collision,
    input  logic       prize_collision,
    input  logic       gate_collision,
    input  logic       step_free_collision,
    output logic [9:0] score,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic       game_active,
    output logic       game_over,
    output logic       player_blink,
    output logic       sound_req
);
    localparam int CNT_MAX = (INVULN_FRAMES > LEVEL_PAUSE_FRAMES) ? INVULN_FRAMES : LEVEL_PAUSE_FRAMES;
    // At least 3 bits so the blink tap (bit 2) always exists
    localparam int CNT_W = ($clog2(CNT_MAX + 1) < 3) ? 3 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INVULN_LOAD = CNT_W'(INVULN_FRAMES);
    localparam logic [CNT_W-1:0] PAUSE_LOAD  = CNT_W'(LEVEL_PAUSE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [9:0]       SCORE_MAX   = 10'd999;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAY       = 3'd1,
        HIT        = 3'd2,
        LEVEL_DONE = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       score_q, score_d;
    logic [1:0]       lives_q, lives_d;
    logic [2:0]       level_q, level_d;
    logic             tile_f_q, tile_f_d;
    logic             prize_f_q, prize_f_d;
    logic             gate_f_q, gate_f_d;
    logic             step_f_q, step_f_d;
    logic             key_q, key_d;
    logic             sound_q, sound_d;

    logic             key_rise;
    logic [10:0]      score_sum;
    logic [9:0]       score_add;
    logic             prize_apply;
    logic             hit_apply;

    always_comb begin
        key_d     = start_key;
        key_rise  = start_key & ~key_q;
        score_sum = {1'b0, score_q} + 11'(PRIZE_POINTS);
        score_add = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];

        state_d     = state_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        lives_d     = lives_q;
        level_d     = level_q;
        sound_d     = 1'b0;
        prize_apply = 1'b0;
        hit_apply   = 1'b0;

        // Flags are consumed on startOfFrame; a same-clk collision seeds the next frame
        if (startOfFrame) begin
            tile_f_d  = tile_collision;
            prize_f_d = prize_collision;
            gate_f_d  = gate_collision;
            step_f_d  = step_free_collision;
        end else begin
            tile_f_d  = tile_f_q  | tile_collision;
            prize_f_d = prize_f_q | prize_collision;
            gate_f_d  = gate_f_q  | gate_collision;
            step_f_d  = step_f_q  | step_free_collision;
        end

        case (state_q)
            IDLE: begin
                if (key_rise) begin
                    state_d   = PLAY;
                    score_d   = 10'd0;
                    lives_d   = 2'd3;
                    level_d   = 3'd0;
                    cnt_d     = '0;
                    tile_f_d  = 1'b0;
                    prize_f_d = 1'b0;
                    gate_f_d  = 1'b0;
                    step_f_d  = 1'b0;
                end
            end
            PLAY: begin
                if (startOfFrame) begin
                    if (gate_f_q) begin
                        state_d = LEVEL_DONE;
                        cnt_d   = PAUSE_LOAD;
                        sound_d = 1'b1;
                    end else begin
                        prize_apply = prize_f_q;
                        hit_apply   = tile_f_q & ~step_f_q;
                        if (hit_apply) begin
                            lives_d = lives_q - 2'd1;
                            if (lives_q == 2'd1) begin
                                state_d = GAME_OVER;
                            end else begin
                                state_d = HIT;
                                cnt_d   = INVULN_LOAD;
                            end
                        end
                    end
                end
            end
            HIT: begin
                if (startOfFrame) begin
                    prize_apply = prize_f_q;
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            LEVEL_DONE: begin
                if (startOfFrame) begin
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = PLAY;
                        if (level_q != 3'd7) level_d = level_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            GAME_OVER: begin
                if (key_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (prize_apply) score_d = score_add;
        if (prize_apply || hit_apply) sound_d = 1'b1;

`ifdef BONUS_LIFE_EN
        // A lost last life wins over a simultaneous bonus
        if (prize_apply && ((score_add / 10'd100) != (score_q / 10'd100)) &&
            (state_d != GAME_OVER) && (lives_d != 2'd3)) begin
            lives_d = lives_d + 2'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            score_q   <= 10'd0;
            lives_q   <= 2'd3;
            level_q   <= 3'd0;
            tile_f_q  <= 1'b0;
            prize_f_q <= 1'b0;
            gate_f_q  <= 1'b0;
            step_f_q  <= 1'b0;
            key_q     <= 1'b0;
            sound_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            tile_f_q  <= tile_f_d;
            prize_f_q <= prize_f_d;
            gate_f_q  <= gate_f_d;
            step_f_q  <= step_f_d;
            key_q     <= key_d;
            sound_q   <= sound_d;
        end
    end

    assign score        = score_q;
    assign lives        = lives_q;
    assign level        = level_q;
    assign game_active  = (state_q == PLAY) || (state_q == HIT);
    assign game_over    = (state_q == GAME_OVER);
    assign player_blink = (state_q == HIT) & cnt_q[2];
    assign sound_req    = sound_q;

endmodule
`default_nettype wire

// File: tb/tb_game_state_manager.sv
`default_nettype none
// ============================================================================
// tb_game_state_manager : directed self-checking bench for game_state_manager.
// Rev 1.0
// ============================================================================
module tb_game_state_manager;
    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       start_key = 1'b0;
    logic       tile_collision = 1'b0;
    logic       prize_collision = 1'b0;
    logic       gate_collision = 1'b0;
    logic       step_free_collision = 1'b0;
    logic [9:0] score;
    logic [1:0] lives;
    logic [2:0] level;
    logic       game_active;
    logic       game_over;
    logic       player_blink;
    logic       sound_req;

    int n_cmp = 0;
    int n_err = 0;
    int sound_cnt = 0;
    int exp_lives;

    game_state_manager dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .start_key           (start_key),
        .tile_collision      (tile_collision),
        .prize_collision     (prize_collision),
        .gate_collision      (gate_collision),
        .step_free_collision (step_free_collision),
        .score               (score),
        .lives               (lives),
        .level               (level),
        .game_active         (game_active),
        .game_over           (game_over),
        .player_blink        (player_blink),
        .sound_req           (sound_req)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sound_req) sound_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic frame();
        @(posedge clk); #1 startOfFrame = 1'b1;
        @(posedge clk); #1 startOfFrame = 1'b0;
    endtask

    task automatic hold(input logic t, input logic p, input logic g, input logic s, input int n);
        tile_collision = t; prize_collision = p; gate_collision = g; step_free_collision = s;
        repeat (n) @(posedge clk);
        #1;
        tile_collision = 1'b0; prize_collision = 1'b0; gate_collision = 1'b0; step_free_collision = 1'b0;
    endtask

    task automatic frame_with(input logic t, input logic p, input logic g, input logic s);
        hold(t, p, g, s, 1);
        frame();
    endtask

    task automatic press();
        start_key = 1'b1;
        @(posedge clk); #1 start_key = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_score", score, 0);
        check("rst_lives", lives, 3);
        check("rst_level", level, 0);
        check("rst_active", game_active, 0);
        check("rst_over", game_over, 0);
        check("rst_blink", player_blink, 0);
        check("rst_sound", sound_req, 0);

        // Start with no startOfFrame after reset release
        resetN = 1'b1;
        settle();
        press();
        check("start_active", game_active, 1);
        check("start_lives", lives, 3);

        // Three prize frames
        frame_with(0, 1, 0, 0);
        check("sound_pulse_hi", sound_req, 1);
        settle();
        check("sound_pulse_lo", sound_req, 0);
        frame_with(0, 1, 0, 0);
        frame_with(0, 1, 0, 0);
        settle();
        check("prize3_score", score, 30);
        check("prize3_lives", lives, 3);
        check("prize3_sound", sound_cnt, 3);

        // Collision on the evaluating clk carries into the next frame
        @(posedge clk); #1;
        startOfFrame = 1'b1; prize_collision = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0; prize_collision = 1'b0;
        check("sameclk_hold", score, 30);
        frame();
        check("sameclk_next", score, 40);

        // Tile with step_free protection
        frame_with(1, 0, 0, 1);
        settle();
        check("stepfree_lives", lives, 3);
        check("stepfree_sound", sound_cnt, 4);
        check("stepfree_active", game_active, 1);

        // Gate plus prize: no points, pause then level up
        frame_with(0, 1, 1, 0);
        check("gate_score", score, 40);
        check("gate_active", game_active, 0);
        frame_with(1, 0, 0, 0);
        repeat (88) frame();
        check("pause89_level", level, 0);
        check("pause_lives", lives, 3);
        frame();
        check("pause90_level", level, 1);
        check("pause90_active", game_active, 1);
        settle();
        check("gate_sound", sound_cnt, 5);

        // Hit, blink pattern, prize and tile inside invulnerability
        repeat (5) frame_with(0, 1, 0, 0);
        check("score90", score, 90);
        hold(1, 0, 0, 0, 5);
        frame();
        check("hit_lives", lives, 2);
        check("hit_blink60", player_blink, 1);
        frame();
        check("blink59", player_blink, 0);
        repeat (3) frame();
        check("blink56", player_blink, 0);
        frame();
        check("blink55", player_blink, 1);
        frame_with(0, 1, 0, 0);
        check("hit_prize_score", score, 100);
`ifdef BONUS_LIFE_EN
        exp_lives = 3;
`else
        exp_lives = 2;
`endif
        check("bonus_lives", lives, exp_lives);
        frame_with(1, 0, 0, 0);
        check("hit_tile_ignored", lives, exp_lives);
        repeat (52) frame();
        frame_with(1, 0, 0, 0);
        check("hit60_tile_ignored", lives, exp_lives);
        check("hit60_active", game_active, 1);
        settle();
        check("hit_sound", sound_cnt, 12);

        // Unprotected hits until game over, start key held into GAME_OVER
        while (exp_lives > 0) begin
            if (exp_lives == 1) start_key = 1'b1;
            frame_with(1, 0, 0, 0);
            exp_lives--;
            check("hit_loop_lives", lives, exp_lives);
            if (exp_lives > 0) repeat (60) frame();
        end
        check("go_over", game_over, 1);
        check("go_active", game_active, 0);
        check("go_score", score, 100);
        check("go_level", level, 1);
        repeat (5) @(posedge clk);
        #1;
        check("go_key_held", game_over, 1);
        start_key = 1'b0;
        settle();
        check("go_key_released", game_over, 1);
        press();
        check("go_to_idle_over", game_over, 0);
        check("go_to_idle_active", game_active, 0);
        press();
        check("restart_active", game_active, 1);
        check("restart_score", score, 0);
        check("restart_lives", lives, 3);
        check("restart_level", level, 0);

        // Score saturation
        repeat (99) frame_with(0, 1, 0, 0);
        check("score990", score, 990);
        repeat (2) frame_with(0, 1, 0, 0);
        check("score_sat", score, 999);
        check("sat_lives", lives, 3);

        // Asynchronous reset in the middle of a level pause
        frame_with(0, 0, 1, 0);
        repeat (3) frame();
        prize_collision = 1'b1;
        @(posedge clk);
        #3 resetN = 1'b0;
        #1;
        check("arst_score", score, 0);
        check("arst_lives", lives, 3);
        check("arst_level", level, 0);
        check("arst_active", game_active, 0);
        prize_collision = 1'b0;
        @(posedge clk); #1 resetN = 1'b1;
        press();
        check("arst_start", game_active, 1);
        frame();
        settle();
        check("arst_frame_score", score, 0);
        check("arst_frame_level", level, 0);
        check("arst_frame_active", game_active, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/game_state_manager.md
GAME_STATE_MANAGER -- requirements
Module: game_state_manager

Interface
REQ-001 SHALL have parameter PRIZE_POINTS, default 10, points added per prize frame.
REQ-002 SHALL have parameter INVULN_FRAMES, default 60, frame count of the post-hit invulnerability window.
REQ-003 SHALL have parameter LEVEL_PAUSE_FRAMES, default 90, frame count of the pause between levels.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port startOfFrame  input  1  one-clk pulse at each frame start.
REQ-007 SHALL have port start_key  input  1  level, player start request.
REQ-008 SHALL have ports tile_collision, prize_collision, gate_collision, step_free_collision  input  1 each  per-pixel collision levels.
REQ-009 SHALL have port score  output  10  binary score, 0..999.
REQ-010 SHALL have port lives  output  2  remaining lives, 0..3.
REQ-011 SHALL have port level  output  3  current level, 0..7.
REQ-012 SHALL have port game_active  output  1  high in PLAY or HIT.
REQ-013 SHALL have port game_over  output  1  high in GAME_OVER.
REQ-014 SHALL have port player_blink  output  1  player-sprite hide request during invulnerability.
REQ-015 SHALL have port sound_req  output  1  one-clk pulse per scored event.

Function
REQ-016 SHALL latch each collision input into its own sticky flag on any clk where the input is high.
REQ-017 SHALL evaluate the sticky flags on startOfFrame, apply the results, and clear the flags in the same clk; a collision asserted on that same clk SHALL be kept for the next frame.
REQ-018 SHALL have FSM states IDLE, PLAY, HIT, LEVEL_DONE, GAME_OVER.
REQ-019 IDLE: SHALL go to PLAY on start_key with score=0, lives=3, level=0.
REQ-020 PLAY, evaluation priority gate > tile > prize.
REQ-021 PLAY, gate flag: SHALL go to LEVEL_DONE and load the frame counter with LEVEL_PAUSE_FRAMES.
REQ-022 PLAY, tile flag with step_free flag clear: SHALL decrement lives; lives reaching 0 SHALL go to GAME_OVER; otherwise SHALL go to HIT and load the counter with INVULN_FRAMES.
REQ-023 PLAY, tile flag with step_free flag set: SHALL ignore the tile hit.
REQ-024 A prize flag SHALL add PRIZE_POINTS to score in PLAY or HIT, also in the same frame as a tile hit, but not in a gate frame; score SHALL saturate at 999.
REQ-025 HIT: SHALL decrement the counter each startOfFrame, ignore tile flags, and return to PLAY when the counter reaches 0.
REQ-026 player_blink SHALL equal counter bit 2 in HIT and be 0 in every other state.
REQ-027 LEVEL_DONE: SHALL ignore all flags and decrement the counter each startOfFrame; at 0 it SHALL increment level (saturating at 7) and go to PLAY.
REQ-028 GAME_OVER: SHALL hold score and level, and go to IDLE on a start_key rising edge.
REQ-029 sound_req SHALL pulse one clk after the evaluating startOfFrame whenever a prize, tile hit, or gate event is applied; there SHALL be at most one pulse per frame.
REQ-030 start_key SHALL be edge-detected internally; a key held from GAME_OVER SHALL NOT restart the game.

Reset
REQ-031 On resetN low, all outputs SHALL be 0 except lives=3, the state SHALL be IDLE, and the counter and sticky flags SHALL clear, regardless of state or an in-progress countdown.
REQ-032 On resetN deassertion, the block SHALL need no startOfFrame before it accepts start_key.

Configuration
REQ-033 With macro BONUS_LIFE_EN defined, a score update crossing a multiple of 100 SHALL increment lives, saturating at 3.
REQ-034 With BONUS_LIFE_EN undefined, lives SHALL change only on start and on tile hits.

Verification
REQ-035 Reset, start_key, 3 prize frames -> score=30, lives=3, 3 sound_req pulses.
REQ-036 Tile collision held 5 clks in one frame -> lives 3->2, state HIT, blink toggles every 4 frames, PLAY after 60 frames; tile in HIT -> lives stays 2.
REQ-037 Tile and step_free collisions in the same frame -> lives unchanged, no sound_req.
REQ-038 Gate and prize collisions in the same frame -> score unchanged, level 0->1 after 90 frames.
REQ-039 Three unprotected hits -> lives=0, game_over=1; start_key held across reset of state -> stays GAME_OVER until release and re-press.
REQ-040 With BONUS_LIFE_EN, score 90 plus prize at lives=2 -> score=100, lives=3; with score at 999 plus prize -> score=999.
